// File: rtl/reg_bus_arbiter.sv
// Two-requester round-robin arbiter in front of a single register-bank port.
// One downstream transaction at a time, each bounded by a wait-for-ack timeout.
module reg_bus_arbiter #(
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       TIMEOUT  = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = 16'hDEAD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_req,
  output logic              s_we,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic              s_ack,
  input  logic [DATA_W-1:0] s_rdata,
  output logic              grant,
  output logic              busy,
  output logic              timeout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                grant_q, grant_d;
  logic                last_q, last_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic                load;
  logic [DATA_W-1:0]   resp_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      grant_q  <= 1'b0;
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    last_d      = last_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    load        = 1'b0;
    resp_data   = s_rdata;
    s_req       = 1'b0;
    m0_ack      = 1'b0;
    m1_ack      = 1'b0;
    timeout_err = 1'b0;

    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          // On a tie the requester not served last wins.
          grant_d = (m0_req && m1_req) ? ~last_q : m1_req;
          if (grant_d) begin
            we_d    = m1_we;
            addr_d  = m1_addr;
            wdata_d = m1_wdata;
          end else begin
            we_d    = m0_we;
            addr_d  = m0_addr;
            wdata_d = m0_wdata;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        s_req   = 1'b1;
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // s_ack takes priority over a timeout landing in the same cycle.
        if (s_ack) begin
          load    = 1'b1;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          load        = 1'b1;
          resp_data   = ERR_DATA;
          timeout_err = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        m0_ack  = ~grant_q;
        m1_ack  = grant_q;
        last_d  = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      if (grant_q) rdata1_d = resp_data;
      else         rdata0_d = resp_data;
    end
  end

  assign s_we     = we_q;
  assign s_addr   = addr_q;
  assign s_wdata  = wdata_q;
  assign grant    = grant_q;
  assign busy     = (state_q != IDLE);
  assign m0_rdata = rdata0_q;
  assign m1_rdata = rdata1_q;

endmodule
